// File: rtl/ptp_tsq_pkg.sv
// Shared types and constants for the PTP timestamp-queue drain engine.
package ptp_tsq_pkg;

  localparam int ENTRY_W         = 128;
  localparam int WORD_W          = 32;
  localparam int WORDS_PER_ENTRY = 4;

  localparam logic SRC_RX = 1'b0;
  localparam logic SRC_TX = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_WAIT,
    ST_SEND,
    ST_GUARD
  } state_t;

  // Word 0 is the most significant slice of the entry.
  function automatic logic [WORD_W-1:0] entry_word(input logic [ENTRY_W-1:0] e,
                                                   input logic [1:0]         i);
    return e[ENTRY_W-1-WORD_W*int'(i) -: WORD_W];
  endfunction

endpackage

// File: rtl/ptp_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module ptp_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ptp_tsq_drain.sv
// Round-robin drain of the RX/TX timestamp queues into a 32-bit valid/ready
// word stream, four words per 128-bit entry, with saturating drain counters.
module ptp_tsq_drain
  import ptp_tsq_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int GUARD  = 2,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  output logic               rx_q_rd_en,
  input  logic [7:0]         rx_q_rd_stat,
  input  logic [ENTRY_W-1:0] rx_q_rd_data,
  output logic               tx_q_rd_en,
  input  logic [7:0]         tx_q_rd_stat,
  input  logic [ENTRY_W-1:0] tx_q_rd_data,
  output logic [WORD_W-1:0]  m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last,
  output logic               m_src,
  output logic [CNT_W-1:0]   rx_cnt,
  output logic [CNT_W-1:0]   tx_cnt,
  output logic               busy
);

  localparam int LAT_W   = 2;
  localparam int GUARD_W = (GUARD > 1) ? $clog2(GUARD) : 1;

  state_t               state, state_nxt;
  logic                 sel, sel_nxt;
  logic                 rr, rr_nxt;
  logic [LAT_W-1:0]     lat_cnt, lat_nxt;
  logic [1:0]           idx, idx_nxt;
  logic [GUARD_W-1:0]   gcnt, gcnt_nxt;
  logic                 load;
  logic                 rx_ne, tx_ne;
  logic                 entry_done;
  logic [ENTRY_W-1:0]   hold;

  assign rx_ne = |rx_q_rd_stat;
  assign tx_ne = |tx_q_rd_stat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      sel     <= SRC_RX;
      rr      <= SRC_RX;
      lat_cnt <= '0;
      idx     <= '0;
      gcnt    <= '0;
    end else begin
      state   <= state_nxt;
      sel     <= sel_nxt;
      rr      <= rr_nxt;
      lat_cnt <= lat_nxt;
      idx     <= idx_nxt;
      gcnt    <= gcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    rr_nxt    = rr;
    lat_nxt   = lat_cnt;
    idx_nxt   = idx;
    gcnt_nxt  = gcnt;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && (rx_ne || tx_ne)) begin
          state_nxt = ST_POP;
          // The pointer only moves when there was an actual contention.
          if (rx_ne && tx_ne) begin
            sel_nxt = rr;
            rr_nxt  = ~rr;
          end else begin
            sel_nxt = tx_ne ? SRC_TX : SRC_RX;
          end
        end
      end
      ST_POP: begin
        state_nxt = ST_WAIT;
        lat_nxt   = '0;
      end
      ST_WAIT: begin
        if (lat_cnt == LAT_W'(RD_LAT - 1)) begin
          load      = 1'b1;
          idx_nxt   = '0;
          state_nxt = ST_SEND;
        end else begin
          lat_nxt = lat_cnt + LAT_W'(1);
        end
      end
      ST_SEND: begin
        if (m_ready) begin
          if (idx == 2'(WORDS_PER_ENTRY - 1)) begin
            state_nxt = (GUARD == 0) ? ST_IDLE : ST_GUARD;
            gcnt_nxt  = '0;
          end else begin
            idx_nxt = idx + 2'd1;
          end
        end
      end
      ST_GUARD: begin
        if (gcnt == GUARD_W'(GUARD - 1)) begin
          state_nxt = ST_IDLE;
        end else begin
          gcnt_nxt = gcnt + GUARD_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Holding register: data path only, qualified by state on the output side.
  always_ff @(posedge clk) begin
    if (load) begin
      hold <= (sel == SRC_TX) ? tx_q_rd_data : rx_q_rd_data;
    end
  end

  assign rx_q_rd_en = (state == ST_POP) && (sel == SRC_RX);
  assign tx_q_rd_en = (state == ST_POP) && (sel == SRC_TX);
  assign m_valid    = (state == ST_SEND);
  assign m_last     = m_valid && (idx == 2'(WORDS_PER_ENTRY - 1));
  assign m_src      = sel;
  assign m_data     = m_valid ? entry_word(hold, idx) : '0;
  assign busy       = (state != ST_IDLE);
  assign entry_done = m_valid && m_ready && (idx == 2'(WORDS_PER_ENTRY - 1));

  ptp_sat_cnt #(.CNT_W(CNT_W)) u_rx_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (entry_done && (sel == SRC_RX)),
    .cnt (rx_cnt)
  );

  ptp_sat_cnt #(.CNT_W(CNT_W)) u_tx_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (entry_done && (sel == SRC_TX)),
    .cnt (tx_cnt)
  );

endmodule

// File: tb/tb_ptp_tsq_drain.sv
// Bench for ptp_tsq_drain: queue models, an entry-timeline reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_ptp_tsq_drain;

  localparam int RD_LAT = 1;
  localparam int GUARD  = 2;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic             m_ready = 1'b1;
  logic [7:0]       rx_stat = '0;
  logic [7:0]       tx_stat = '0;
  logic [127:0]     rx_data = '0;
  logic [127:0]     tx_data = '0;
  logic             rx_rd_en, tx_rd_en;
  logic [31:0]      m_data;
  logic             m_valid, m_last, m_src, busy;
  logic [CNT_W-1:0] rx_cnt, tx_cnt;

  ptp_tsq_drain #(.RD_LAT(RD_LAT), .GUARD(GUARD), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .rx_q_rd_en   (rx_rd_en),
    .rx_q_rd_stat (rx_stat),
    .rx_q_rd_data (rx_data),
    .tx_q_rd_en   (tx_rd_en),
    .tx_q_rd_stat (tx_stat),
    .tx_q_rd_data (tx_data),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last),
    .m_src        (m_src),
    .rx_cnt       (rx_cnt),
    .tx_cnt       (tx_cnt),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  logic [127:0] rx_q[$];
  logic [127:0] tx_q[$];
  logic [31:0]  obs_w[$];
  bit           obs_last[$];
  bit           obs_src[$];
  bit           pop_log[$];
  bit           rx_pend, tx_pend;
  bit           started;
  int           total, passed;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    else passed++;
  endtask

  task automatic refresh_stat();
    rx_stat = (rx_q.size() > 255) ? 8'd255 : 8'(rx_q.size());
    tx_stat = (tx_q.size() > 255) ? 8'd255 : 8'(tx_q.size());
  endtask

  // Queue read port: data appears the cycle after the strobe (RD_LAT=1).
  task automatic tick();
    @(posedge clk);
    #1;
    if (rx_pend && rx_q.size() > 0) rx_data = rx_q.pop_front();
    if (tx_pend && tx_q.size() > 0) tx_data = tx_q.pop_front();
    refresh_stat();
  endtask

  task automatic push_rx(input logic [127:0] d);
    rx_q.push_back(d);
    refresh_stat();
  endtask

  task automatic push_tx(input logic [127:0] d);
    tx_q.push_back(d);
    refresh_stat();
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic clear_logs();
    obs_w.delete();
    obs_last.delete();
    obs_src.delete();
    pop_log.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    bit done = 1'b0;
    for (int k = 0; k < limit; k++) begin
      tick();
      if (rx_q.size() == 0 && tx_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain_done", 32'(done), 32'd1);
  endtask

  task automatic wait_word(input logic [31:0] w);
    bit found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (m_valid && m_data == w) begin
        found = 1'b1;
        break;
      end
    end
    chk("saw_word", 32'(found), 32'd1);
  endtask

  // Reference model: each entry follows a fixed timeline after its decision
  // cycle d: strobe at d+1, words from d+2+RD_LAT, idle GUARD cycles after
  // the final transfer. Outputs are compared on every cycle.
  int           cyc = 0;
  bit           in_entry = 1'b0;
  int           next_free = 0;
  int           pop_cyc, send_start, widx;
  bit           msrc, rr;
  logic [127:0] ent;
  int           m_rxc = 0, m_txc = 0;

  always @(negedge clk) begin
    logic [127:0] sh;
    bit           exp_busy, exp_valid;
    cyc++;
    rx_pend = rx_rd_en;
    tx_pend = tx_rd_en;
    if (rx_rd_en) pop_log.push_back(1'b0);
    if (tx_rd_en) pop_log.push_back(1'b1);
    if (started) begin
      chk("rx_cnt", 32'(rx_cnt), 32'(m_rxc));
      chk("tx_cnt", 32'(tx_cnt), 32'(m_txc));
      exp_busy = in_entry || (cyc < next_free);
      if (!in_entry && cyc >= next_free && !rst && enable &&
          (rx_stat != 0 || tx_stat != 0)) begin
        if (rx_stat != 0 && tx_stat != 0) begin
          msrc = rr;
          rr   = ~rr;
        end else begin
          msrc = (tx_stat != 0);
        end
        in_entry   = 1'b1;
        pop_cyc    = cyc + 1;
        send_start = cyc + 2 + RD_LAT;
        ent        = msrc ? tx_q[0] : rx_q[0];
        widx       = 0;
      end
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("rx_rd_en", 32'(rx_rd_en), 32'(in_entry && cyc == pop_cyc && !msrc));
      chk("tx_rd_en", 32'(tx_rd_en), 32'(in_entry && cyc == pop_cyc && msrc));
      exp_valid = in_entry && (cyc >= send_start);
      chk("m_valid", 32'(m_valid), 32'(exp_valid));
      if (exp_valid) begin
        sh = ent >> (96 - 32 * widx);
        chk("m_data", m_data, sh[31:0]);
        chk("m_last", 32'(m_last), 32'(widx == 3));
        chk("m_src", 32'(m_src), 32'(msrc));
        if (m_ready) begin
          obs_w.push_back(m_data);
          obs_last.push_back(m_last);
          obs_src.push_back(m_src);
          widx++;
          if (widx == 4) begin
            if (!msrc && m_rxc < CMAX) m_rxc++;
            if (msrc && m_txc < CMAX) m_txc++;
            in_entry  = 1'b0;
            next_free = cyc + 1 + GUARD;
          end
        end
      end
      if (rst) begin
        in_entry  = 1'b0;
        next_free = cyc + 1;
        m_rxc     = 0;
        m_txc     = 0;
        rr        = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t1w [4];
    t1w = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};

    tick();
    started = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rx_cnt", 32'(rx_cnt), 32'd0);
    chk("rst_tx_cnt", 32'(tx_cnt), 32'd0);
    chk("rst_rd_en", 32'({rx_rd_en, tx_rd_en}), 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_m_last_src", 32'({m_last, m_src}), 32'd0);

    // Single RX entry, MS word first
    clear_logs();
    m_ready = 1'b1;
    enable  = 1'b1;
    push_rx(128'h00112233_44556677_8899AABB_CCDDEEFF);
    wait_done(100);
    chk("t1_words", 32'(obs_w.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_word", (i < obs_w.size()) ? obs_w[i] : 32'hDEADBEEF, t1w[i]);
      chk("t1_last", (i < obs_last.size()) ? 32'(obs_last[i]) : 32'd9, 32'(i == 3));
      chk("t1_src", (i < obs_src.size()) ? 32'(obs_src[i]) : 32'd9, 32'd0);
    end
    chk("t1_pops", 32'(pop_log.size()), 32'd1);
    chk("t1_rx_cnt", 32'(rx_cnt), 32'd1);

    // Round robin with both queues holding two entries
    do_reset();
    clear_logs();
    push_rx(rnd128());
    push_rx(rnd128());
    push_tx(rnd128());
    push_tx(rnd128());
    wait_done(200);
    chk("t2_pops", 32'(pop_log.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("t2_pop_src", (i < pop_log.size()) ? 32'(pop_log[i]) : 32'd9, 32'(i % 2));
    chk("t2_rx_cnt", 32'(rx_cnt), 32'd2);
    chk("t2_tx_cnt", 32'(tx_cnt), 32'd2);

    // Backpressure for five cycles on word 1
    clear_logs();
    push_rx(128'hA0A0A0A0_44556677_B1B1B1B1_C2C2C2C2);
    wait_word(32'h44556677);
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_valid", 32'(m_valid), 32'd1);
      chk("t3_stall_data", m_data, 32'h44556677);
      tick();
    end
    m_ready = 1'b1;
    wait_done(100);
    chk("t3_pops", 32'(pop_log.size()), 32'd1);
    chk("t3_words", 32'(obs_w.size()), 32'd4);
    chk("t3_last_word", (obs_w.size() == 4) ? obs_w[3] : 32'hDEADBEEF, 32'hC2C2C2C2);
    chk("t3_rx_cnt", 32'(rx_cnt), 32'd3);

    // enable dropped during word 2
    clear_logs();
    push_rx(128'h11111111_22222222_33333333_44444444);
    push_rx(rnd128());
    wait_word(32'h33333333);
    enable = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    chk("t4_words", 32'(obs_w.size()), 32'd4);
    chk("t4_pops_held", 32'(pop_log.size()), 32'd1);
    chk("t4_rx_cnt", 32'(rx_cnt), 32'd4);
    chk("t4_idle", 32'(busy), 32'd0);
    enable = 1'b1;
    wait_done(100);
    chk("t4_pops", 32'(pop_log.size()), 32'd2);
    chk("t4_rx_cnt2", 32'(rx_cnt), 32'd5);

    // Reset during word 2
    clear_logs();
    push_rx(128'h55555555_66666666_77777777_88888888);
    wait_word(32'h77777777);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_m_valid", 32'(m_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_cnts", 32'({rx_cnt, tx_cnt}), 32'd0);
    clear_logs();
    push_rx(rnd128());
    push_tx(rnd128());
    wait_done(100);
    chk("t5_first_rx", (pop_log.size() > 0) ? 32'(pop_log[0]) : 32'd9, 32'd0);
    chk("t5_rx_cnt", 32'(rx_cnt), 32'd1);
    chk("t5_tx_cnt", 32'(tx_cnt), 32'd1);

    // Randomized traffic, ready and enable
    for (int c = 0; c < 2500; c++) begin
      tick();
      if (rx_q.size() < 12 && $urandom_range(0, 9) == 0) push_rx(rnd128());
      if (tx_q.size() < 12 && $urandom_range(0, 9) == 0) push_tx(rnd128());
      m_ready = ($urandom_range(0, 3) != 0);
      enable  = ($urandom_range(0, 7) != 0);
    end
    enable  = 1'b1;
    m_ready = 1'b1;
    wait_done(600);

    // Counter saturation with 17 RX entries
    do_reset();
    for (int i = 0; i < 17; i++) push_rx(rnd128());
    for (int c = 0; c < 1200 && (rx_q.size() != 0 || busy); c++) begin
      tick();
      m_ready = ($urandom_range(0, 3) != 0);
    end
    m_ready = 1'b1;
    wait_done(100);
    chk("t7_rx_sat", 32'(rx_cnt), 32'(CMAX));
    chk("t7_tx_cnt", 32'(tx_cnt), 32'd0);

    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
